wb_regfile: RTL and testbench

Write-back stage and architectural register file of the pipelined processor. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32-entry register file. It serves the decode stage's two read ports with same-cycle write-back bypass and exports the selected write-back value to the forwarding unit. A committed-write counter and a debug read port support verification.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/regfile_bank.sv | 37 +++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath width and register file geometry.
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_bank.sv
// Architectural register storage: NREGS x DATA_W, async clear, one write
// port, three combinational read ports. Zero-register and bypass handling
// live in the caller.
module regfile_bank
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic [ADDR_W-1:0] raddr_d,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_d
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage update: clear everything on reset, otherwise single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register
// bank, serves two decode read ports with same-cycle bypass, and counts
// committed writes.
module wb_regfile
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite_in,
    input  logic              memtoreg_in,
    input  logic [DATA_W-1:0] readdata_in,
    input  logic [DATA_W-1:0] aluresult_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wb_count
);

    logic [DATA_W-1:0] bank_a;
    logic [DATA_W-1:0] bank_b;
    logic [DATA_W-1:0] bank_d;
    logic [31:0]       count_q;

    // Write-back mux stays live during reset so forwarding always sees it.
    assign wb_data  = memtoreg_in ? readdata_in : aluresult_in;
    assign wb_valid = regwrite_in && (rd_in != REG_ZERO) && !rst;
    assign wb_count = count_q;

    regfile_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_valid),
        .waddr   (rd_in),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .raddr_d (dbg_addr),
        .rdata_a (bank_a),
        .rdata_b (bank_b),
        .rdata_d (bank_d)
    );

    // Decode read ports: reset/zero first, then write-through bypass, then storage.
    always_comb begin
        rs_data = bank_a;
        rt_data = bank_b;
        if (rst || rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (wb_valid && rs_addr == rd_in) begin
            rs_data = wb_data;
        end
        if (rst || rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (wb_valid && rt_addr == rd_in) begin
            rt_data = wb_data;
        end
    end

    // Debug port reads storage only; no bypass.
    always_comb begin
        dbg_data = bank_d;
        if (rst || dbg_addr == REG_ZERO) begin
            dbg_data = '0;
        end
    end

    // Committed-write counter, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (wb_valid) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected read/write-back values are
// queued when stimulus is launched on the falling edge and compared mid-cycle.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regwrite_in = 1'b0;
    logic        memtoreg_in = 1'b0;
    logic [31:0] readdata_in = '0;
    logic [31:0] aluresult_in = '0;
    logic [4:0]  rd_in = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] rs_data, rt_data, wb_data, dbg_data, wb_count;
    logic        wb_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] dbg;
        logic [31:0] wbd;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m [32];
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .regwrite_in  (regwrite_in),
        .memtoreg_in  (memtoreg_in),
        .readdata_in  (readdata_in),
        .aluresult_in (aluresult_in),
        .rd_in        (rd_in),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_data      (wb_data),
        .wb_valid     (wb_valid),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .wb_count     (wb_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic v,
                                          input logic [4:0] rd, input logic [31:0] d);
        if (a == 5'd0) return 32'd0;
        if (v && a == rd) return d;
        return m[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m[i] = '0;
        mcnt = '0;
    endtask

    // One cycle: launch on falling edge, check mid-cycle, commit model at rising edge.
    task automatic cyc(input logic rw, input logic mtr, input logic [4:0] rd,
                       input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rdbg);
        exp_t e, g;
        @(negedge clk);
        regwrite_in = rw; memtoreg_in = mtr; rd_in = rd;
        readdata_in = rdat; aluresult_in = alu;
        rs_addr = ra; rt_addr = rb; dbg_addr = rdbg;
        e.wbd = mtr ? rdat : alu;
        e.v   = rw && (rd != 5'd0);
        e.rs  = mread(ra, e.v, rd, e.wbd);
        e.rt  = mread(rb, e.v, rd, e.wbd);
        e.dbg = (rdbg == 5'd0) ? 32'd0 : m[rdbg];
        e.cnt = mcnt;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk("rs_data",  rs_data,  g.rs);
        chk("rt_data",  rt_data,  g.rt);
        chk("dbg_data", dbg_data, g.dbg);
        chk("wb_data",  wb_data,  g.wbd);
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, g.v});
        chk("wb_count", wb_count, g.cnt);
        @(posedge clk);
        if (e.v) begin
            m[rd] = e.wbd;
            mcnt  = mcnt + 32'd1;
        end
        #1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Commit ALU then memory data to r5.
        cyc(1, 0, 5, 32'h0, 32'h1234_5678, 0, 0, 5);
        cyc(0, 0, 0, 32'h0, 32'h0, 5, 0, 5);
        cyc(1, 1, 5, 32'hDEAD_BEEF, 32'h0, 0, 0, 5);
        cyc(0, 0, 0, 32'h0, 32'h0, 5, 5, 5);
        chk("count_after_two", wb_count, 32'd2);

        // Bypass on r7: disabled write first, then enabled.
        cyc(1, 0, 7, 32'h0, 32'h0000_0011, 0, 0, 0);
        cyc(0, 0, 7, 32'h0, 32'hA5A5_A5A5, 7, 7, 7);
        cyc(1, 0, 7, 32'h0, 32'hA5A5_A5A5, 7, 7, 7);
        cyc(0, 0, 0, 32'h0, 32'h0, 7, 7, 7);

        // Register zero write is discarded.
        cyc(1, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
        cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);

        // Counter wrap.
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        mcnt = 32'hFFFF_FFFF;
        cyc(1, 0, 9, 32'h0, 32'h0000_0099, 0, 0, 9);
        cyc(0, 0, 0, 32'h0, 32'h0, 9, 0, 9);
        chk("count_wrap", wb_count, 32'd0);

        // Reset mid-run with a write pending across the edge.
        @(negedge clk);
        regwrite_in = 1; memtoreg_in = 0; rd_in = 5'd3; aluresult_in = 32'h3333_3333;
        rs_addr = 5'd5; rt_addr = 5'd3; dbg_addr = 5'd7;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_rs", rs_data, 32'd0);
        chk("rst_rt", rt_data, 32'd0);
        chk("rst_dbg", dbg_data, 32'd0);
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wbdata", wb_data, 32'h3333_3333);
        chk("rst_count", wb_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        regwrite_in = 0;
        rst = 1'b0;
        model_clear();
        #1;
        cyc(0, 0, 0, 32'h0, 32'h0, 3, 5, 3);
        chk("post_rst_count", wb_count, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            logic [4:0] rd, ra, rb, rdbg;
            rd = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rdbg = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
                $urandom, $urandom, ra, rb, rdbg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
